exec_sequencer: RTL
===================

# exec_sequencer

Multi-cycle fetch/decode/execute/writeback controller for the 8-bit accumulator CPU. Owns the program counter, accumulator and flag register; fetches instructions from instruction memory over a req/ack handshake, drives register-file read/write ports and the 2-bit ALU opcode, and sequences one instruction at a time. Sits between `instruction_memory`, `register_file` and `alu`, and replaces the free-running PC increment in the top level.

## Interface
- `PC_W`, 16, program counter / imem address width
- `DATA_W`, 8, datapath width
- `RA_W`, 4, register-file address width
- Clock `clock`, reset `reset`: one clock; reset is synchronous and active-high.
- `clock` in 1: rising-edge clock
- `reset` in 1: synchronous, active-high
- `run` in 1: level; allows starting/continuing instruction issue
- `imem_req` out 1: fetch request, held until ack
- `imem_addr` out PC_W: fetch address (= pc)
- `imem_ack` in 1: fetch data valid this cycle
- `imem_data` in 8: instruction
- `rf_rd_addr` out RA_W: register read index
- `rf_rd_data` in DATA_W: combinational read data
- `rf_wr_enable` out 1: one-cycle write strobe
- `rf_wr_addr` out RA_W; `rf_wr_data` out DATA_W
- `alu_op` out 2; `alu_a`, `alu_b` out DATA_W; `alu_result` in DATA_W; `alu_zero`, `alu_carry`, `alu_overflow` in 1
- `acc` out DATA_W; `zero`, `carry`, `overflow` out 1: architectural flags
- `retired` out 1: one-cycle pulse per completed instruction
- `halted` out 1: level, sticky until reset

## Operation
- Encoding: `[7:6]` alu op, `[5:2]` r, `[1:0]` mode. Modes: 00 LOAD (acc←R[r]); 01 ALU (acc←acc op R[r], flags←ALU flags); 10 STORE (R[r]←acc); 11 r=0 HALT, r≠0 BZ (if zero, pc←pc+sext(r)+1, else pc+1; r is 4-bit two's complement).
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: run=1 → FETCH, else stay.
- FETCH: imem_req=1, imem_addr=pc; on imem_ack latch imem_data into ir → DECODE. ack while not in FETCH ignored.
- DECODE: rf_rd_addr=ir.r; sample rf_rd_data into opb → EXEC.
- EXEC: alu_a=acc, alu_b=opb, alu_op=ir[7:6]; latch alu_result and flags into temporaries → WB.
- WB: commit per mode; STORE drives rf_wr_enable=1, rf_wr_addr=r, rf_wr_data=acc this cycle only. pc←pc+1 (or branch target); retired=1. HALT: do not advance pc, go HALT. Otherwise run=1 → FETCH, run=0 → IDLE.
- Flags change only on ALU-mode WB. LOAD does not update zero.
- PC arithmetic modulo 2^PC_W: 0xFFFF+1→0x0000; branch targets wrap likewise.
- run deassertion mid-instruction: current instruction completes; stop at WB.

## Timing
- Reset values: pc=0, acc=0, flags=0, state IDLE, imem_req=0, rf_wr_enable=0, retired=0, halted=0, rf_rd_addr=0, alu_op=0, imem_addr=0.
- Minimum 4 cycles/instruction (FETCH with same-cycle ack, DECODE, EXEC, WB); each imem wait cycle adds one.
- imem_req rises the cycle after entering FETCH from IDLE/WB, stays high until the ack cycle inclusive, low the following cycle.
- Reset mid-fetch: imem_req low the cycle after reset sampled; a late ack is ignored.
- rf_wr_enable and retired are single-cycle, coincident, in WB.
- halted asserts the cycle after the HALT WB; run and imem_ack ignored thereafter.

## Structure
- Package `seq_pkg`: state enum, mode constants (MODE_LOAD/ALU/STORE/CTRL), ALU opcode constants shared with `alu`, instruction field typedef.
- One sub-module: `seq_decode`, combinational instruction field/mode decode (is_halt, is_branch, writes_acc, writes_rf).
- Registers and FSM in `exec_sequencer`.

## Test plan
- Reset then run=1, imem returns 0x00 (LOAD R0) with ack same cycle: imem_req at cycle 1, retired at cycle 4, pc=1, acc=R0.
- Program LOAD R1(=0x7F), ALU add R2(=0x01): acc=0x80, overflow=1, carry=0, zero=0; STORE R3 → rf_wr_enable one cycle, addr 3, data 0x80.
- imem_ack delayed 3 cycles: imem_req held 4 cycles, instruction retires at cycle 7; spurious ack in EXEC ignored.
- Flags zero=1, BZ r=0xE (−2) at pc=0x0010 → pc=0x000F; zero=0 → pc=0x0011; pc=0xFFFF non-branch → 0x0000.
- HALT (0x03): halted=1 after WB, pc unchanged, no further imem_req despite run=1; reset clears halted, pc=0.
- run dropped during DECODE: instruction retires, FSM in IDLE, no new imem_req; reset asserted mid-FETCH → all outputs at reset values next cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the accumulator CPU sequencer: FSM states,
// instruction modes, ALU opcodes and the packed instruction layout.
package seq_pkg;
  localparam int PC_W   = 16;
  localparam int DATA_W = 8;
  localparam int RA_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] MODE_LOAD  = 2'b00;
  localparam logic [1:0] MODE_ALU   = 2'b01;
  localparam logic [1:0] MODE_STORE = 2'b10;
  localparam logic [1:0] MODE_CTRL  = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef struct packed {
    logic [1:0]      op;
    logic [RA_W-1:0] r;
    logic [1:0]      mode;
  } instr_t;

  // Branch offset is a 4-bit two's complement field; target wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] pc,
                                                     input logic [RA_W-1:0] off);
    return pc + {{(PC_W-RA_W){off[RA_W-1]}}, off} + PC_W'(1);
  endfunction
endpackage

// File: rtl/exec_sequencer_if.sv
// Bus bundle between the sequencer (master) and imem / register file / ALU (slave).
// imem: imem_req is held until the cycle imem_ack is high; that cycle carries imem_data.
interface exec_sequencer_if;
  logic                       imem_req;
  logic [seq_pkg::PC_W-1:0]   imem_addr;
  logic                       imem_ack;
  logic [7:0]                 imem_data;
  logic [seq_pkg::RA_W-1:0]   rf_rd_addr;
  logic [seq_pkg::DATA_W-1:0] rf_rd_data;
  logic                       rf_wr_enable;
  logic [seq_pkg::RA_W-1:0]   rf_wr_addr;
  logic [seq_pkg::DATA_W-1:0] rf_wr_data;
  logic [1:0]                 alu_op;
  logic [seq_pkg::DATA_W-1:0] alu_a;
  logic [seq_pkg::DATA_W-1:0] alu_b;
  logic [seq_pkg::DATA_W-1:0] alu_result;
  logic                       alu_zero;
  logic                       alu_carry;
  logic                       alu_overflow;

  modport master (
    output imem_req, imem_addr, rf_rd_addr, rf_wr_enable, rf_wr_addr, rf_wr_data,
           alu_op, alu_a, alu_b,
    input  imem_ack, imem_data, rf_rd_data, alu_result, alu_zero, alu_carry, alu_overflow
  );

  modport slave (
    input  imem_req, imem_addr, rf_rd_addr, rf_wr_enable, rf_wr_addr, rf_wr_data,
           alu_op, alu_a, alu_b,
    output imem_ack, imem_data, rf_rd_data, alu_result, alu_zero, alu_carry, alu_overflow
  );
endinterface

// File: rtl/seq_decode.sv
// Combinational split of the instruction register into fields and mode qualifiers.
module seq_decode import seq_pkg::*; (
  input  instr_t          i_ir,
  output logic [1:0]      o_alu_op,
  output logic [RA_W-1:0] o_r,
  output logic [1:0]      o_mode,
  output logic            o_is_halt,
  output logic            o_is_branch,
  output logic            o_writes_acc,
  output logic            o_writes_rf,
  output logic            o_writes_flags
);
  assign o_alu_op       = i_ir.op;
  assign o_r            = i_ir.r;
  assign o_mode         = i_ir.mode;
  assign o_is_halt      = (i_ir.mode == MODE_CTRL) && (i_ir.r == '0);
  assign o_is_branch    = (i_ir.mode == MODE_CTRL) && (i_ir.r != '0);
  assign o_writes_acc   = (i_ir.mode == MODE_LOAD) || (i_ir.mode == MODE_ALU);
  assign o_writes_rf    = (i_ir.mode == MODE_STORE);
  assign o_writes_flags = (i_ir.mode == MODE_ALU);
endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller for the 8-bit accumulator CPU.
// Owns pc, acc and flags; issues one instruction at a time.
module exec_sequencer import seq_pkg::*; (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  exec_sequencer_if.master    bus,
  output logic [DATA_W-1:0]   acc,
  output logic                zero,
  output logic                carry,
  output logic                overflow,
  output logic                retired,
  output logic                halted,
  output state_t              dbg_state
);
  state_t              r_state, w_next;
  logic [PC_W-1:0]     r_pc;
  logic [DATA_W-1:0]   r_acc, r_opb, r_res;
  logic                r_zero, r_carry, r_overflow;
  logic                r_t_zero, r_t_carry, r_t_overflow;
  logic                r_halted;
  instr_t              r_ir;

  logic [1:0]          w_alu_op, w_mode;
  logic [RA_W-1:0]     w_r;
  logic                w_is_halt, w_is_branch, w_writes_acc, w_writes_rf, w_writes_flags;

  seq_decode u_decode (
    .i_ir           (r_ir),
    .o_alu_op       (w_alu_op),
    .o_r            (w_r),
    .o_mode         (w_mode),
    .o_is_halt      (w_is_halt),
    .o_is_branch    (w_is_branch),
    .o_writes_acc   (w_writes_acc),
    .o_writes_rf    (w_writes_rf),
    .o_writes_flags (w_writes_flags)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_pc         <= '0;
      r_acc        <= '0;
      r_opb        <= '0;
      r_res        <= '0;
      r_zero       <= 1'b0;
      r_carry      <= 1'b0;
      r_overflow   <= 1'b0;
      r_t_zero     <= 1'b0;
      r_t_carry    <= 1'b0;
      r_t_overflow <= 1'b0;
      r_halted     <= 1'b0;
      r_ir         <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_FETCH:  if (bus.imem_ack) r_ir <= instr_t'(bus.imem_data);
        ST_DECODE: r_opb <= bus.rf_rd_data;
        ST_EXEC: begin
          r_res        <= bus.alu_result;
          r_t_zero     <= bus.alu_zero;
          r_t_carry    <= bus.alu_carry;
          r_t_overflow <= bus.alu_overflow;
        end
        ST_WB: begin
          if (w_is_halt) begin
            r_halted <= 1'b1;
          end else begin
            r_pc <= (w_is_branch && r_zero) ? branch_target(r_pc, w_r) : r_pc + PC_W'(1);
            if (w_writes_acc) r_acc <= (w_mode == MODE_LOAD) ? r_opb : r_res;
            if (w_writes_flags) begin
              r_zero     <= r_t_zero;
              r_carry    <= r_t_carry;
              r_overflow <= r_t_overflow;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next           = r_state;
    bus.imem_req     = 1'b0;
    bus.rf_rd_addr   = '0;
    bus.rf_wr_enable = 1'b0;
    bus.rf_wr_addr   = '0;
    bus.rf_wr_data   = '0;
    bus.alu_op       = '0;
    bus.alu_a        = '0;
    bus.alu_b        = '0;
    retired          = 1'b0;
    case (r_state)
      ST_IDLE:   if (run) w_next = ST_FETCH;
      ST_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) w_next = ST_DECODE;
      end
      ST_DECODE: begin
        bus.rf_rd_addr = w_r;
        w_next         = ST_EXEC;
      end
      ST_EXEC: begin
        bus.alu_op = w_alu_op;
        bus.alu_a  = r_acc;
        bus.alu_b  = r_opb;
        w_next     = ST_WB;
      end
      ST_WB: begin
        retired = 1'b1;
        if (w_writes_rf) begin
          bus.rf_wr_enable = 1'b1;
          bus.rf_wr_addr   = w_r;
          bus.rf_wr_data   = r_acc;
        end
        if (w_is_halt) w_next = ST_HALT;
        else           w_next = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT:   w_next = ST_HALT;
      default:   w_next = ST_IDLE;
    endcase
  end

  assign bus.imem_addr = r_pc;
  assign acc           = r_acc;
  assign zero          = r_zero;
  assign carry         = r_carry;
  assign overflow      = r_overflow;
  assign halted        = r_halted;
  assign dbg_state     = r_state;
endmodule
